// File: rtl/usf_sample_window.sv
// Sample windowing front end for the modulo-folded ADC recovery path.
// Fills a shadow window of N samples and commits it to win_out, with a minimum hold between commits.
module usf_sample_window #(
  parameter int          N          = 13,
  parameter int          W          = 12,
  parameter int          HOLD       = 48,
  parameter logic [15:0] FRAME_INIT = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [N-1:0][W-1:0]  win_out,
  output logic                 en,
  output logic [15:0]          frame_cnt
);

  localparam int             IW        = $clog2(N + 1);
  localparam int             HW        = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [IW-1:0]  IDX_FULL  = IW'(N);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD);

  logic [IW-1:0]         idx_q,    idx_d;
  logic [HW-1:0]         hold_q,   hold_d;
  logic [N-1:0][W-1:0]   shadow_q, shadow_d;
  logic [N-1:0][W-1:0]   win_q,    win_d;
  logic                  en_q,     en_d;
  logic [15:0]           frame_q,  frame_d;
  logic                  accept_s;
  logic                  commit_s;

  // in_ready is combinational on the fill index so a full shadow backpressures at once.
  assign in_ready  = (idx_q < IDX_FULL);
  assign accept_s  = in_valid && in_ready && !flush;
  assign commit_s  = (idx_q == IDX_FULL) && (hold_q == {HW{1'b0}}) && !flush;

  assign win_out   = win_q;
  assign en        = en_q;
  assign frame_cnt = frame_q;

  // Next-state: flush beats commit beats accept; accept and commit are exclusive by idx.
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    win_d    = win_q;
    en_d     = 1'b0;
    frame_d  = frame_q;
    if (hold_q != {HW{1'b0}}) begin
      hold_d = hold_q - HW'(1'b1);
    end else begin
      hold_d = {HW{1'b0}};
    end

    if (flush) begin
      idx_d = {IW{1'b0}};
    end else if (commit_s) begin
      win_d   = shadow_q;
      en_d    = 1'b1;
      idx_d   = {IW{1'b0}};
      hold_d  = HOLD_LOAD;
      frame_d = frame_q + 16'd1;
    end else if (accept_s) begin
      idx_d = idx_q + IW'(1'b1);
      for (int i = 0; i < N; i++) begin
        if (idx_q == IW'(i)) begin
          shadow_d[i] = in_data;
        end else begin
          shadow_d[i] = shadow_q[i];
        end
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= {IW{1'b0}};
      hold_q   <= {HW{1'b0}};
      shadow_q <= '0;
      win_q    <= '0;
      en_q     <= 1'b0;
      frame_q  <= FRAME_INIT;
    end else begin
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      win_q    <= win_d;
      en_q     <= en_d;
      frame_q  <= frame_d;
    end
  end

endmodule
